// File: rtl/ula_mc_pkg.sv
// Shared opcode constants and FSM encoding for the multi-cycle arithmetic unit.
// The processor decoder and the combinational ALU mux use the same opcodes.
package ula_mc_pkg;

    localparam logic [4:0] OP_MLT = 5'd3;
    localparam logic [4:0] OP_DIV = 5'd4;
    localparam logic [4:0] OP_MOD = 5'd5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_FIX  = 2'd2
    } state_e;

    function automatic logic op_enabled(input logic [4:0] op,
                                        input logic en_mlt,
                                        input logic en_div,
                                        input logic en_mod);
        return (op == OP_MLT && en_mlt) ||
               (op == OP_DIV && en_div) ||
               (op == OP_MOD && en_mod);
    endfunction

endpackage

// File: rtl/ula_mc_step.sv
// One iteration of the sequential datapath: shift-add multiply step or
// restoring-division step, on unsigned magnitudes.
module ula_mc_step
    import ula_mc_pkg::*;
#(
    parameter int NUBITS = 32
) (
    input  logic [4:0]        op_i,
    input  logic [NUBITS-1:0] a_i,    // MLT: multiplicand, DIV/MOD: dividend -> quotient
    input  logic [NUBITS-1:0] b_i,    // MLT: multiplier,   DIV/MOD: divisor
    input  logic [NUBITS:0]   acc_i,  // MLT: product,      DIV/MOD: remainder
    output logic [NUBITS-1:0] a_o,
    output logic [NUBITS-1:0] b_o,
    output logic [NUBITS:0]   acc_o
);

    logic [NUBITS:0] rem_sh;
    logic            rem_ge;

    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        a_o    = a_i;
        b_o    = b_i;
        acc_o  = acc_i;
        rem_sh = '0;
        rem_ge = 1'b0;

        if (op_i == OP_MLT) begin
            // Carry into bit NUBITS is harmless; only the low NUBITS are used.
            if (b_i[0]) begin
                acc_o = acc_i + {1'b0, a_i};
            end
            a_o = a_i << 1;
            b_o = b_i >> 1;
        end else begin
            rem_sh = {acc_i[NUBITS-1:0], a_i[NUBITS-1]};
            rem_ge = (rem_sh >= {1'b0, b_i});
            acc_o  = rem_ge ? (rem_sh - {1'b0, b_i}) : rem_sh;
            a_o    = {a_i[NUBITS-2:0], rem_ge};
        end
    end

endmodule

// File: rtl/ula_mc.sv
// Multi-cycle MLT/DIV/MOD unit with start/busy/done handshake; one bit per
// clock in RUN, sign correction and result registration in FIX.
module ula_mc
    import ula_mc_pkg::*;
#(
    parameter int NUBITS = 32,
    parameter int MLT    = 1,
    parameter int DIV    = 1,
    parameter int MOD    = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [4:0]               op,
    input  logic signed [NUBITS-1:0] in1,
    input  logic signed [NUBITS-1:0] in2,
    output logic                     busy,
    output logic                     done,
    output logic signed [NUBITS-1:0] out,
    output logic                     is_zero,
    output logic                     dz
);

    localparam int CW = $clog2(NUBITS + 1);

    state_e            state_q, state_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [NUBITS-1:0] a_q, a_d, b_q, b_d;
    logic [NUBITS:0]   acc_q, acc_d;
    logic [4:0]        op_q, op_d;
    logic              sa_q, sa_d, sb_q, sb_d, zdiv_q, zdiv_d;
    logic [NUBITS-1:0] out_q, out_d;
    logic              is_zero_q, is_zero_d, dz_q, dz_d, done_q, done_d;

    logic [NUBITS-1:0] in1_u, in2_u, abs1, abs2, a_step, b_step, res;
    logic [NUBITS:0]   acc_step;
    logic              is_div_op;

    function automatic logic [NUBITS-1:0] neg_if(input logic c, input logic [NUBITS-1:0] x);
        return c ? (~x + 1'b1) : x;
    endfunction

    assign in1_u     = in1;
    assign in2_u     = in2;
    assign abs1      = neg_if(in1_u[NUBITS-1], in1_u);
    assign abs2      = neg_if(in2_u[NUBITS-1], in2_u);
    assign is_div_op = (op == OP_DIV) || (op == OP_MOD);

    ula_mc_step #(.NUBITS(NUBITS)) u_step (
        .op_i  (op_q),
        .a_i   (a_q),
        .b_i   (b_q),
        .acc_i (acc_q),
        .a_o   (a_step),
        .b_o   (b_step),
        .acc_o (acc_step)
    );

    // Sign fix with truncation semantics; the zero-divisor case bypasses the datapath.
    always_comb begin
        res = '0;
        unique case (op_q)
            OP_MLT:  res = neg_if(sa_q ^ sb_q, acc_q[NUBITS-1:0]);
            OP_DIV:  res = zdiv_q ? '1 : neg_if(sa_q ^ sb_q, a_q);
            default: res = zdiv_q ? neg_if(sa_q, a_q) : neg_if(sa_q, acc_q[NUBITS-1:0]);
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        a_d       = a_q;
        b_d       = b_q;
        acc_d     = acc_q;
        op_d      = op_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        zdiv_d    = zdiv_q;
        out_d     = out_q;
        is_zero_d = is_zero_q;
        dz_d      = dz_q;
        done_d    = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (start && op_enabled(op, MLT != 0, DIV != 0, MOD != 0)) begin
                    a_d    = abs1;
                    b_d    = abs2;
                    acc_d  = '0;
                    op_d   = op;
                    sa_d   = in1_u[NUBITS-1];
                    sb_d   = in2_u[NUBITS-1];
                    cnt_d  = CW'(NUBITS);
                    zdiv_d = is_div_op && (in2_u == '0);
                    state_d = (is_div_op && (in2_u == '0)) ? ST_FIX : ST_RUN;
                end
            end
            ST_RUN: begin
                a_d   = a_step;
                b_d   = b_step;
                acc_d = acc_step;
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == CW'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                out_d     = res;
                is_zero_d = (res == '0);
                dz_d      = zdiv_q;
                done_d    = 1'b1;
                state_d   = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: reset is synchronous, so it lives inside the clocked block's if/else.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            a_q       <= '0;
            b_q       <= '0;
            acc_q     <= '0;
            op_q      <= '0;
            sa_q      <= 1'b0;
            sb_q      <= 1'b0;
            zdiv_q    <= 1'b0;
            out_q     <= '0;
            is_zero_q <= 1'b1;
            dz_q      <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            a_q       <= a_d;
            b_q       <= b_d;
            acc_q     <= acc_d;
            op_q      <= op_d;
            sa_q      <= sa_d;
            sb_q      <= sb_d;
            zdiv_q    <= zdiv_d;
            out_q     <= out_d;
            is_zero_q <= is_zero_d;
            dz_q      <= dz_d;
            done_q    <= done_d;
        end
    end

    assign busy    = (state_q != ST_IDLE);
    assign done    = done_q;
    assign out     = out_q;
    assign is_zero = is_zero_q;
    assign dz      = dz_q;

endmodule

// File: tb/tb_ula_mc.sv
// Self-checking bench for ula_mc: directed corner cases plus random operations
// compared against a plain-arithmetic reference model.
module tb_ula_mc;
    import ula_mc_pkg::*;

    localparam int N = 32;

    logic                clk = 1'b0;
    logic                rst, start;
    logic [4:0]          op;
    logic signed [N-1:0] in1, in2;
    logic signed [N-1:0] out;
    logic                busy, done, is_zero, dz;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ula_mc #(.NUBITS(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .op      (op),
        .in1     (in1),
        .in2     (in2),
        .busy    (busy),
        .done    (done),
        .out     (out),
        .is_zero (is_zero),
        .dz      (dz)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // C-style truncating arithmetic on 32-bit ints, with the zero-divisor rules.
    function automatic void model(input logic [4:0] o, input int a, input int b,
                                  output int r, output logic z);
        z = 1'b0;
        r = 0;
        if (o == OP_MLT) begin
            r = a * b;
        end else if (b == 0) begin
            z = 1'b1;
            r = (o == OP_DIV) ? -1 : a;
        end else if (a == int'(32'h8000_0000) && b == -1) begin
            r = (o == OP_DIV) ? a : 0;
        end else begin
            r = (o == OP_DIV) ? a / b : a % b;
        end
    endfunction

    // Issue one operation starting in the current cycle; returns in the done cycle.
    task automatic run_op(input string tag, input logic [4:0] o, input int a, input int b,
                          input int intr);
        int   r;
        logic z;
        int   lat;
        model(o, a, b, r, z);
        start = 1'b1; op = o; in1 = a; in2 = b;
        @(posedge clk); #1;
        start = 1'b0;
        check({tag, " busy"}, 32'(busy), 32'(1));
        lat = 0;
        while (done !== 1'b1 && lat < 80) begin
            if (intr != 0 && lat == intr) begin
                start = 1'b1; op = OP_MLT; in1 = 2; in2 = 3;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start = 1'b0;
        check({tag, " latency"}, 32'(lat), z ? 32'(1) : 32'(N + 1));
        check({tag, " out"}, out, r);
        check({tag, " dz"}, 32'(dz), 32'(z));
        check({tag, " is_zero"}, 32'(is_zero), 32'(r == 0));
        check({tag, " busy_done"}, 32'(busy), 32'(0));
    endtask

    initial begin
        int seen;
        rst = 1'b1; start = 1'b0; op = '0; in1 = '0; in2 = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst busy", 32'(busy), 32'(0));
        check("rst done", 32'(done), 32'(0));
        check("rst out", out, 32'(0));
        check("rst is_zero", 32'(is_zero), 32'(1));
        check("rst dz", 32'(dz), 32'(0));
        rst = 1'b0;
        @(posedge clk); #1;

        // Consecutive calls also exercise back-to-back starts in the done cycle.
        run_op("div_pos", OP_DIV, 100, 7, 0);
        run_op("mod_pos", OP_MOD, 100, 7, 0);
        run_op("div_nega", OP_DIV, -100, 7, 0);
        run_op("mod_nega", OP_MOD, -100, 7, 0);
        run_op("div_negb", OP_DIV, 100, -7, 0);
        run_op("mod_negb", OP_MOD, 100, -7, 0);
        run_op("mlt_neg", OP_MLT, 12345, -3, 0);
        run_op("mlt_wrap", OP_MLT, 32'h0001_0000, 32'h0001_0000, 0);
        run_op("div_zero", OP_DIV, 5, 0, 0);
        run_op("mod_zero", OP_MOD, 5, 0, 0);
        run_op("div_ovf", OP_DIV, int'(32'h8000_0000), -1, 0);
        run_op("mod_ovf", OP_MOD, int'(32'h8000_0000), -1, 0);
        run_op("div_again", OP_DIV, 100, 7, 0);
        @(posedge clk); #1;
        check("done_single", 32'(done), 32'(0));

        start = 1'b1; op = 5'd2; in1 = 9; in2 = 9;
        @(posedge clk); #1;
        start = 1'b0;
        check("op2 busy", 32'(busy), 32'(0));
        seen = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("op2 no_done", 32'(seen), 32'(0));
        check("op2 out_held", out, 32'(14));

        run_op("div_busy_start", OP_DIV, 100, 7, 5);

        start = 1'b1; op = OP_DIV; in1 = 1000; in2 = 3;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midrst busy", 32'(busy), 32'(0));
        check("midrst out", out, 32'(0));
        check("midrst is_zero", 32'(is_zero), 32'(1));
        check("midrst dz", 32'(dz), 32'(0));
        rst = 1'b0;
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done === 1'b1) seen++;
        end
        check("midrst no_done", 32'(seen), 32'(0));

        run_op("after_rst", OP_MOD, -100, 7, 0);

        for (int i = 0; i < 40; i++) begin
            logic [4:0] ro;
            int         ra, rb;
            ro = 5'(3 + $urandom_range(2));
            ra = ($urandom_range(7) == 0) ? int'(32'h8000_0000) : int'($urandom);
            case ($urandom_range(5))
                0:       rb = 0;
                1:       rb = -1;
                2:       rb = int'($urandom_range(40)) - 20;
                default: rb = int'($urandom);
            endcase
            run_op($sformatf("rand%0d", i), ro, ra, rb, 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
